matrix_scan_capture: RTL
========================

Name: matrix_scan_capture

Overview:
- Sits on the opposite side of the LED-matrix scan interface that the game core drives (16 row lines, 16 column lines).
- Samples the multiplexed row/column scan and rebuilds the full 16x16 frame in a double-buffered frame store.
- Exposes the frame through a registered read port, with a frame-complete strobe and counter.
- Used for on-board frame checking and for forwarding the displayed field to a host/debug path.

Parameters:
- N, 16, number of rows and columns; the index width is log2(N) = 4.
- ROW_ACT, 1, active level of the scan row lines (1 = active-high).
- COL_ACT, 0, active level of the scan column lines (0 = active-low; a lit pixel is col=0).
- STABLE, 4, consecutive cycles a one-hot row must hold before its columns are captured (range 2..255).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset; synchronous, active-high.
- scan_row  input  16  row scan lines, sampled every clk.
- scan_col  input  16  column scan lines, sampled every clk.
- rd_addr  input  4  row index to read from the display buffer.
- rd_data  output  16  pixel bits of row rd_addr; 1 = lit; bit i = column i.
- frame_valid  output  1  one-cycle pulse when a complete frame is committed.
- frame_cnt  output  8  number of committed frames, wraps 255->0.
- err_multi  output  1  sticky flag: a multi-hot row pattern was seen.

Behaviour:
- Input stage: scan_row and scan_col are registered once; all logic below uses the registered copies.
- Normalisation: r = ROW_ACT ? row : ~row; c = COL_ACT ? col : ~col. After this, 1 means active or lit.
- Row classification: r==0 means blank; exactly one bit set means valid, with index k; two or more bits set means multi.
- FSM states: IDLE, SETTLE, HOLD.
  - IDLE: on valid r, latch r as cur_row, set stab_cnt=1, go to SETTLE. On blank, stay in IDLE. On multi, set err_multi and stay in IDLE.
  - SETTLE: if r==cur_row, stab_cnt++. When stab_cnt reaches STABLE-1 with r still equal, capture in that cycle: work_buf[k] <= c and seen[k] <= 1, then go to HOLD.
  - SETTLE exits: if r changes to another valid row, restart SETTLE with the new row and stab_cnt=1. If r goes blank, go to IDLE. If r goes multi, set err_multi and go to IDLE.
  - HOLD: while r==cur_row, no further capture (one capture per row dwell). On a change, take the same exits as SETTLE (new valid row, blank, or multi).
- Capture latency: the first capture happens STABLE+1 clks after a new row appears on scan_row (1 input register + STABLE stability cycles).
- Re-scan before completion: if the same row index is captured again before the frame completes, it overwrites work_buf[k]; the last value wins.
- Frame commit: in the cycle after the capture that makes seen==16'hFFFF:
  - disp_buf <= work_buf;
  - frame_valid=1 for that single cycle;
  - frame_cnt++;
  - seen <= 0.
  - work_buf is not cleared.
- Read port: rd_data <= disp_buf[rd_addr] on every clk, giving 1-cycle latency.
  - A read in the same cycle as a commit returns the pre-commit contents; the new frame is visible from the next read.
- Reset behaviour: rst high in any cycle, including mid-dwell or mid-frame, forces the following on the next edge, and any partially built frame is discarded:
  - state=IDLE, stab_cnt=0, cur_row=0, seen=0;
  - work_buf and disp_buf all rows cleared to 0;
  - rd_data=0, frame_valid=0, frame_cnt=0, err_multi=0.
- err_multi clears only on rst.
- Widths: stab_cnt is 8 bits and saturates; it never wraps.

Test Plan:
- Reset, then scan rows 0..15 in order, each held 8 clks, with col=~(16'h0001<<k) (active-low, one pixel per row on the diagonal). Required: exactly one frame_valid pulse, frame_cnt=1, and rd_addr=k gives rd_data=16'h0001<<k one clk later.
- Row 3 held only STABLE-1 clks, then row 4. Required: row 3 is not captured, seen[3]=0, and no frame_valid even after rows 0..2 and 4..15 are scanned.
- Full frame, then a second frame in which row 5 has col=16'h0000 (all lit). Required: frame_cnt=2, rd_data at addr 5 = 16'hFFFF, and all other rows are unchanged.
- Drive scan_row=16'h0011 for 6 clks. Required: err_multi=1 and stays 1 through later valid frames, with no capture occurring for that pattern; rst then clears it to 0.
- Hold rd_addr=2 during the commit cycle. Required: rd_data shows the old row 2 in the commit cycle and the new value in the next cycle.
- Scan rows 0..9, assert rst for 1 clk, then scan a full frame. Required: frame_valid fires only after all 16 rows following reset, and frame_cnt=1.

Source files
------------

// File: rtl/matrix_scan_capture.sv
`default_nettype none
// ============================================================================
// Module      : matrix_scan_capture
// Description : Rebuilds a 16x16 LED frame from the multiplexed row/column scan
//               into a double-buffered frame store with a registered read port.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_scan_capture #(
    parameter int N       = 16,
    parameter bit ROW_ACT = 1'b1,
    parameter bit COL_ACT = 1'b0,
    parameter int STABLE  = 4,
    localparam int IW     = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  scan_row,
    input  logic [N-1:0]  scan_col,
    input  logic [IW-1:0] rd_addr,
    output logic [N-1:0]  rd_data,
    output logic          frame_valid,
    output logic [7:0]    frame_cnt,
    output logic          err_multi
);

    localparam logic [1:0]   S_IDLE    = 2'd0;
    localparam logic [1:0]   S_SETTLE  = 2'd1;
    localparam logic [1:0]   S_HOLD    = 2'd2;
    localparam logic [7:0]   STAB_LAST = 8'(STABLE - 1);
    localparam logic [N-1:0] ONE       = {{(N-1){1'b0}}, 1'b1};
    localparam logic [N-1:0] ROW_BLANK = ROW_ACT ? {N{1'b0}} : {N{1'b1}};
    localparam logic [N-1:0] COL_DARK  = COL_ACT ? {N{1'b0}} : {N{1'b1}};

    logic [N-1:0]  row_q;
    logic [N-1:0]  col_q;
    logic [N-1:0]  w_r;
    logic [N-1:0]  w_c;
    logic          w_blank;
    logic          w_multi;
    logic          w_valid;
    logic          w_same;
    logic [IW-1:0] w_idx;

    logic [1:0]    state_q, state_d;
    logic [N-1:0]  cur_row_q, cur_row_d;
    logic [7:0]    stab_q, stab_d;
    logic [N-1:0]  seen_q, seen_d;
    logic          err_q, err_d;
    logic          w_cap;
    logic          w_commit;

    logic [N-1:0]  work_buf_q [N];
    logic [N-1:0]  disp_buf_q [N];
    logic [N-1:0]  rd_data_q;
    logic          frame_valid_q;
    logic [7:0]    frame_cnt_q;

    // Input stage: everything downstream works on these registered copies
    always_ff @(posedge clk) begin
        if (rst) begin
            row_q <= ROW_BLANK;
            col_q <= COL_DARK;
        end else begin
            row_q <= scan_row;
            col_q <= scan_col;
        end
    end

    assign w_r = ROW_ACT ? row_q : ~row_q;
    assign w_c = COL_ACT ? col_q : ~col_q;

    always_comb begin
        w_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (w_r[i]) begin
                w_idx = IW'(i);
            end
        end
    end

    // Clearing the lowest set bit leaves something only for multi-hot rows
    assign w_blank = (w_r == '0);
    assign w_multi = !w_blank && ((w_r & (w_r - ONE)) != '0);
    assign w_valid = !w_blank && !w_multi;
    assign w_same  = (w_r == cur_row_q);

    always_comb begin
        state_d   = state_q;
        cur_row_d = cur_row_q;
        stab_d    = stab_q;
        w_cap     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (w_valid) begin
                    cur_row_d = w_r;
                    stab_d    = 8'd1;
                    state_d   = S_SETTLE;
                end
            end
            S_SETTLE, S_HOLD: begin
                if (w_same) begin
                    if (state_q == S_SETTLE) begin
                        if (stab_q >= STAB_LAST) begin
                            w_cap   = 1'b1;
                            state_d = S_HOLD;
                        end
                        if (stab_q != 8'hFF) begin
                            stab_d = stab_q + 8'd1;
                        end
                    end
                end else if (w_valid) begin
                    cur_row_d = w_r;
                    stab_d    = 8'd1;
                    state_d   = S_SETTLE;
                end else begin
                    stab_d  = 8'd0;
                    state_d = S_IDLE;
                end
            end
            default: begin
                stab_d  = 8'd0;
                state_d = S_IDLE;
            end
        endcase
    end

    // A commit fires the cycle after the last missing row is captured
    assign w_commit = (seen_q == {N{1'b1}});
    assign err_d    = err_q | w_multi;

    always_comb begin
        seen_d = w_commit ? '0 : seen_q;
        if (w_cap) begin
            seen_d[w_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            cur_row_q     <= '0;
            stab_q        <= 8'd0;
            seen_q        <= '0;
            err_q         <= 1'b0;
            rd_data_q     <= '0;
            frame_valid_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
            for (int i = 0; i < N; i++) begin
                work_buf_q[i] <= '0;
                disp_buf_q[i] <= '0;
            end
        end else begin
            state_q       <= state_d;
            cur_row_q     <= cur_row_d;
            stab_q        <= stab_d;
            seen_q        <= seen_d;
            err_q         <= err_d;
            rd_data_q     <= disp_buf_q[rd_addr];
            frame_valid_q <= w_commit;
            if (w_cap) begin
                work_buf_q[w_idx] <= w_c;
            end
            if (w_commit) begin
                frame_cnt_q <= frame_cnt_q + 8'd1;
                for (int i = 0; i < N; i++) begin
                    disp_buf_q[i] <= work_buf_q[i];
                end
            end
        end
    end

    assign rd_data     = rd_data_q;
    assign frame_valid = frame_valid_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_multi   = err_q;

endmodule
`default_nettype wire
